// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared constants and FSM encoding for the fetch controller
package msrv32_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/msrv32_fetch_timer.sv
// rtl/msrv32_fetch_timer.sv - wait-cycle counter that flags an instruction-memory timeout
module msrv32_fetch_timer #(
  parameter int IMEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int            CW   = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMEM_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Expires on the last permitted wait cycle, so WAIT lasts exactly IMEM_TIMEOUT cycles.
  assign expired_out = enable_in && (count_q == LAST);

  // Clear while outside WAIT so every entry starts from zero; saturate at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && !expired_out) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// rtl/msrv32_fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect and timeout
module msrv32_fetch_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 8
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] pc_in,
  input  logic        branch_taken_in,
  input  logic        trap_taken_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        fetch_err_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         timer_expired;

  assign redirect    = branch_taken_in | trap_taken_in;
  assign redirect_pc = align_pc(pc_in);

  msrv32_fetch_timer #(
    .IMEM_TIMEOUT(IMEM_TIMEOUT)
  ) u_timer (
    .clk        (ms_riscv32_mp_clk_in),
    .rst        (ms_riscv32_mp_rst_in),
    .clear_in   (state_q != S_WAIT),
    .enable_in  (state_q == S_WAIT),
    .expired_out(timer_expired)
  );

  assign imem_req_out    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign imem_addr_out   = fetch_pc_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_q;
  assign instr_valid_out = valid_q;
  assign flush_out       = (state_q == S_FLUSH);
  assign fetch_err_out   = err_q;

  // Next-state logic. A redirect seen while a request is outstanding is parked in
  // pend_pc_q so the bus address stays stable until the stale response drains.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    case (state_q)
      S_FLUSH: begin
        valid_d = 1'b0;
        state_d = S_REQ;
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_FLUSH;
        end
      end
      S_REQ, S_WAIT: begin
        if (imem_ack_in) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc;
            valid_d    = 1'b0;
            pend_d     = 1'b0;
            state_d    = S_FLUSH;
          end else if (pend_q) begin
            fetch_pc_d = pend_pc_q;
            pend_d     = 1'b0;
            state_d    = S_FLUSH;
          end else begin
            instr_d    = imem_rdata_in;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INC;
            state_d    = S_HOLD;
          end
        end else begin
          if (redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
            valid_d   = 1'b0;
          end
          if (state_q == S_REQ) begin
            state_d = S_WAIT;
          end else if (timer_expired) begin
            err_d = 1'b1;
            if (redirect || pend_q) begin
              // Nothing to retry: the abandoned fetch would be discarded anyway.
              fetch_pc_d = redirect ? redirect_pc : pend_pc_q;
              pend_d     = 1'b0;
              state_d    = S_FLUSH;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          valid_d    = 1'b0;
          state_d    = S_FLUSH;
        end else if (!stall_in) begin
          // Decode consumes the word this cycle; drop valid so it is not taken twice.
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= S_FLUSH;
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// tb/tb_msrv32_fetch_ctrl.sv - table-driven bench with fetched-word scoreboard
module tb_msrv32_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in_s = '0;
  logic        branch_s = 1'b0;
  logic        trap_s = 1'b0;
  logic        stall_s = 1'b0;
  logic        ack_s = 1'b0;
  logic [31:0] rdata_s = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        flush_out;
  logic        fetch_err_out;

  msrv32_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_TIMEOUT(8)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .pc_in               (pc_in_s),
    .branch_taken_in     (branch_s),
    .trap_taken_in       (trap_s),
    .stall_in            (stall_s),
    .imem_req_out        (imem_req_out),
    .imem_addr_out       (imem_addr_out),
    .imem_ack_in         (ack_s),
    .imem_rdata_in       (rdata_s),
    .instr_out           (instr_out),
    .pc_out              (pc_out),
    .instr_valid_out     (instr_valid_out),
    .flush_out           (flush_out),
    .fetch_err_out       (fetch_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        tr;
    logic [31:0] pc_in;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        cap;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  sb_t  cur;
  vec_t v;
  int   checks = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic br, input logic tr, input logic [31:0] pci, input logic st,
                              input logic ak, input logic [31:0] rd, input logic cp,
                              input logic rq, input logic [31:0] ad, input logic fl,
                              input logic vl, input logic er);
    vec_t r;
    r.br = br; r.tr = tr; r.pc_in = pci; r.stall = st; r.ack = ak; r.rdata = rd; r.cap = cp;
    r.e_req = rq; r.e_addr = ad; r.e_flush = fl; r.e_valid = vl; r.e_err = er;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait-state streaming from reset.
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h0,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0000,1,     1,32'h0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h4,0,1,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0001,1,     1,32'h4,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h8,0,1,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0002,1,     1,32'h8,0,0,0));
    // Five stalled HOLD cycles, then release.
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,0,1, 0,0,0, 0,32'hC,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'hC,0,1,0));
    // Ack after three extra cycles.
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0, 0,0,0, 1,32'hC,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0003,1,     1,32'hC,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h10,0,1,0));
    // Branch during WAIT: stale word discarded, one flush, refetch at 0x100.
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h10,0,0,0));
    vecs.push_back(mk(1,0,32'h103,0, 0,0,0,           1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hDEAD_BEEF,0,     1,32'h10,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h100,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0004,1,     1,32'h100,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h104,0,1,0));
    // No ack: REQ plus eight WAIT cycles, then error pulse and retry at the same address.
    for (int k = 0; k < 9; k++) vecs.push_back(mk(0,0,0,0, 0,0,0, 1,32'h104,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0005,1,     1,32'h104,0,0,1));
    // Trap redirect beats stall; target at the top of the address space.
    vecs.push_back(mk(0,1,32'hFFFF_FFFE,1, 0,0,0,     0,32'h108,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'hFFFF_FFFC,1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'hA000_0006,1,     1,32'hFFFF_FFFC,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h0,0,1,0));
    // Redirect coinciding with ack drops the word.
    vecs.push_back(mk(1,0,32'h200,0, 1,32'hBAD0_BAD0,0, 1,32'h0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 0,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h200,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h200,0,0,0));

    cur.pc = 32'h0;
    cur.instr = 32'h0000_0013;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      branch_s = v.br;
      trap_s   = v.tr;
      pc_in_s  = v.pc_in;
      stall_s  = v.stall;
      ack_s    = v.ack;
      rdata_s  = v.rdata;
      if (v.cap) sb_q.push_back('{pc: v.e_addr, instr: v.rdata});
      #4;
      chk("imem_req",   i + 1, {31'b0, imem_req_out},    {31'b0, v.e_req});
      chk("imem_addr",  i + 1, imem_addr_out,            v.e_addr);
      chk("flush",      i + 1, {31'b0, flush_out},       {31'b0, v.e_flush});
      chk("instr_valid",i + 1, {31'b0, instr_valid_out}, {31'b0, v.e_valid});
      chk("fetch_err",  i + 1, {31'b0, fetch_err_out},   {31'b0, v.e_err});
      if (instr_valid_out && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow cycle=%0d actual=%h expected=none", i + 1, instr_out);
        end else begin
          cur = sb_q.pop_front();
        end
      end
      if (v.e_valid) begin
        chk("instr_out", i + 1, instr_out, cur.instr);
        chk("pc_out",    i + 1, pc_out,    cur.pc);
      end
      prev_valid = instr_valid_out;
      @(posedge clk);
      #1;
    end

    // Reset in the middle of WAIT with a response arriving at the same time.
    ack_s   = 1'b1;
    rdata_s = 32'h1234_5678;
    #2 rst = 1'b1;
    #1;
    chk("rst_req",   0, {31'b0, imem_req_out},    32'h0);
    chk("rst_addr",  0, imem_addr_out,            32'h0);
    chk("rst_instr", 0, instr_out,                32'h0000_0013);
    chk("rst_pc",    0, pc_out,                   32'h0);
    chk("rst_valid", 0, {31'b0, instr_valid_out}, 32'h0);
    chk("rst_flush", 0, {31'b0, flush_out},       32'h1);
    chk("rst_err",   0, {31'b0, fetch_err_out},   32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    ack_s = 1'b0;
    #4;
    chk("rel_c1_flush", 1, {31'b0, flush_out},    32'h1);
    chk("rel_c1_req",   1, {31'b0, imem_req_out}, 32'h0);
    @(posedge clk);
    #4;
    chk("rel_c2_req",   2, {31'b0, imem_req_out}, 32'h1);
    chk("rel_c2_addr",  2, imem_addr_out,         32'h0);
    chk("rel_c2_flush", 2, {31'b0, flush_out},    32'h0);

    chk("sb_empty", 0, sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
